imm_gen_stage: RTL
==================

Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-generation stage for the decode pipeline.
- Takes a raw 32-bit RISC-V instruction, decodes the immediate format from the opcode and emits an XLEN-wide immediate together with a format tag.
- Supports I, S, B, U, J, shift-amount and CSR-zimm formats.
- Valid/ready handshake on both sides; 2-entry elastic buffer so upstream never stalls on a single-cycle downstream stall.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- SHAMT_W, $clog2(XLEN), width of the shift-amount field taken from instr[20 +: SHAMT_W].

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush; drops all buffered entries.
- in_valid  input  1  instruction present.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  32  raw instruction word.
- out_valid  output  1  immediate present.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  generated immediate.
- out_fmt  output  3  imm_fmt_e tag.
- out_illegal  output  1  opcode has no known format.

Behaviour:
Reset (async, rst_n=0):
- out_valid=0, in_ready=1, out_imm=0, out_fmt=FMT_NONE, out_illegal=0.
- Both buffer entries are invalid.

Decode (combinational, on in_instr), where op=instr[6:0] and f3=instr[14:12]:
- op 0000011, 1100111, or 0010011 with f3 not 001/101 -> I: sext(instr[31:20]).
- op 0010011 with f3=001/101 -> SH: zext(instr[20 +: SHAMT_W]). funct6/funct7 bits are excluded.
- op 1110011 with f3[2]=1 -> Z: zext(instr[19:15]).
- op 1110011 with f3[2]=0 -> I.
- op 0100011 -> S: sext({instr[31:25], instr[11:7]}).
- op 1100011 -> B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- op 0110111, 0010111 -> U: sext({instr[31:12], 12'b0}) to XLEN. With XLEN=64, bit 31 replicates into [63:32].
- op 1101111 -> J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Any other op -> FMT_NONE, imm=0, illegal=1.

Buffering:
- Output register (entry 0) plus skid register (entry 1).
- Latency is 1 cycle: a transfer at edge N is visible on out_* after edge N.
- in_ready is registered and equals !skid_valid.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Entry 0 empty, or entry 0 draining this cycle: new data goes to entry 0. If the skid holds data, the skid moves to entry 0 and the new data goes to the skid.
- Entry 0 full and stalled: new data goes to the skid, and in_ready drops on the next cycle.
- Simultaneous in and out transfers keep occupancy constant with no bubble.
- Order is strictly FIFO. No entry is ever overwritten.
- out_* hold stable while out_valid=1 and out_ready=0.

Flush:
- The cycle after flush, both entries are invalid and in_ready=1.
- An input presented during the flush cycle is discarded.
- Flush has priority over every transfer.

Reset mid-transfer: all state clears immediately and pending data is lost.

Decomposition:
- Package imm_pkg holds:
  - imm_fmt_e, 3 bits: FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH, FMT_Z.
  - Opcode localparams: OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM.
- Sub-module imm_decode: purely combinational, parametrised by XLEN. Inputs: instr. Outputs: imm, fmt, illegal.
- imm_gen_stage instantiates imm_decode once and adds the 2-entry elastic buffer.

Test Plan:
- XLEN=32, out_ready=1, stream:
  - 0xFFF00093 -> imm 0xFFFFFFFF, FMT_I.
  - 0xFE112E23 -> 0xFFFFFFFC, FMT_S.
  - 0xFE000CE3 -> 0xFFFFFFF8, FMT_B.
  - 0x123450B7 -> 0x12345000, FMT_U.
  - 0x0010006F -> 0x00000800, FMT_J.
  - Each result appears 1 cycle after acceptance, back-to-back with no bubbles.
- XLEN=64:
  - 0x43F0D093 (srai, shamt 63) -> 0x000000000000003F, FMT_SH.
  - 0x800000B7 -> 0xFFFFFFFF80000000, FMT_U.
  - 0xFFF00093 -> all ones, FMT_I.
- Illegal and CSR cases:
  - Instr 0x0000007F -> out_illegal=1, imm 0, FMT_NONE.
  - csrrwi 0x340FD073 -> FMT_Z, imm 0x1F.
- Backpressure:
  - Hold out_ready=0 and offer 3 instructions.
  - Required: first two accepted, in_ready=0 from the cycle after the second, third held upstream.
  - Release out_ready: all three emerge in order, 1 per cycle, with out_* stable while stalled.
- Flush with both entries full plus in_valid=1:
  - Next cycle: out_valid=0, in_ready=1.
  - The flushed-cycle input never appears on the output.
- Assert rst_n=0 asynchronously mid-stream (between edges):
  - out_valid falls immediately and in_ready=1.
  - After release, the first new instruction emerges with 1-cycle latency.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the
// immediate-generation decode stage.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_Z    = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: picks the
// format from the opcode and builds an XLEN value.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] i32;
  logic [31:0] s32;
  logic [31:0] b32;
  logic [31:0] u32;
  logic [31:0] j32;
  logic        is_i;
  logic        is_sh;
  logic        is_z;
  logic        is_s;
  logic        is_b;
  logic        is_u;
  logic        is_j;

  assign op = instr[6:0];
  assign f3 = instr[14:12];

  assign i32 = {{20{instr[31]}}, instr[31:20]};
  assign s32 = {{20{instr[31]}},
                instr[31:25], instr[11:7]};
  assign b32 = {{19{instr[31]}}, instr[31],
                instr[7], instr[30:25],
                instr[11:8], 1'b0};
  assign u32 = {instr[31:12], 12'b0};
  assign j32 = {{11{instr[31]}}, instr[31],
                instr[19:12], instr[20],
                instr[30:21], 1'b0};

  // f3 of 001/101 under OP-IMM are the shifts
  assign is_sh = (op == OP_IMM) &&
                 (f3[1:0] == 2'b01);
  assign is_z  = (op == OP_SYSTEM) && f3[2];
  assign is_i  = (op == OP_LOAD) ||
                 (op == OP_JALR) ||
                 ((op == OP_IMM) && !is_sh) ||
                 ((op == OP_SYSTEM) && !f3[2]);
  assign is_s  = (op == OP_STORE);
  assign is_b  = (op == OP_BRANCH);
  assign is_u  = (op == OP_LUI) ||
                 (op == OP_AUIPC);
  assign is_j  = (op == OP_JAL);

  // one-hot format select; unknown opcodes flag illegal
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (1'b1)
      is_i: begin
        imm = XLEN'($signed(i32));
        fmt = FMT_I;
      end
      is_sh: begin
        imm = XLEN'(instr[20 +: SHAMT_W]);
        fmt = FMT_SH;
      end
      is_z: begin
        imm = XLEN'(instr[19:15]);
        fmt = FMT_Z;
      end
      is_s: begin
        imm = XLEN'($signed(s32));
        fmt = FMT_S;
      end
      is_b: begin
        imm = XLEN'($signed(b32));
        fmt = FMT_B;
      end
      is_u: begin
        imm = XLEN'($signed(u32));
        fmt = FMT_U;
      end
      is_j: begin
        imm = XLEN'($signed(j32));
        fmt = FMT_J;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate stage: decoder followed by a
// 2-entry elastic buffer (output reg + skid reg).
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_e        out_fmt,
  output logic            out_illegal
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_ill;

  logic            v0;
  logic            v1;
  logic [XLEN-1:0] imm0;
  logic [XLEN-1:0] imm1;
  imm_fmt_e        fmt0;
  imm_fmt_e        fmt1;
  logic            ill0;
  logic            ill1;
  logic            xin;
  logic            xout;

  imm_decode #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_dec (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  assign in_ready    = !v1;
  assign xin         = in_valid & in_ready;
  assign xout        = v0 & out_ready;
  assign out_valid   = v0;
  assign out_imm     = imm0;
  assign out_fmt     = fmt0;
  assign out_illegal = ill0;

  // entry 0 refills from skid first, else from input;
  // a stalled entry 0 diverts input into the skid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0   <= 1'b0;
      v1   <= 1'b0;
      imm0 <= '0;
      imm1 <= '0;
      fmt0 <= FMT_NONE;
      fmt1 <= FMT_NONE;
      ill0 <= 1'b0;
      ill1 <= 1'b0;
    end else if (flush) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else if (!v0 || xout) begin
      if (v1) begin
        v0   <= 1'b1;
        v1   <= 1'b0;
        imm0 <= imm1;
        fmt0 <= fmt1;
        ill0 <= ill1;
      end else begin
        v0 <= xin;
        if (xin) begin
          imm0 <= dec_imm;
          fmt0 <= dec_fmt;
          ill0 <= dec_ill;
        end
      end
    end else if (xin) begin
      v1   <= 1'b1;
      imm1 <= dec_imm;
      fmt1 <= dec_fmt;
      ill1 <= dec_ill;
    end
  end

endmodule
